shared_mem_ctrl: RTL and testbench
==================================

Name: shared_mem_ctrl

Overview:
- Responder end of the core-to-shared-memory load/store interface. Owns the 4096 x 8 shared memory.
- Arbitrates the mem_req_ld / mem_req_st requests of all gpu cores round-robin and serves one access at a time.
- Returns a one-cycle val_data pulse per completed access, with load data on the matching mem_dat lane.
- A host port preloads and inspects memory between kernel runs.

Parameters:
- NUM_CORES, 16, number of core request lanes (power of two, 2..16).
- ADDR_W, 12, shared memory address width; depth = 2**ADDR_W.
- DATA_W, 8, data width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req_ld  in  NUM_CORES  per-core load request, held by core until it samples val_data.
- mem_req_st  in  NUM_CORES  per-core store request, same holding rule.
- addr_shared_memory  in  NUM_CORES*ADDR_W  per-core address; lane k = bits [k*ADDR_W +: ADDR_W].
- mem_dat_st  in  NUM_CORES*DATA_W  per-core store data, same lane packing.
- mem_dat  out  NUM_CORES*DATA_W  per-core load data.
- val_data  out  NUM_CORES  per-core one-cycle completion pulse (load and store).
- host_en  in  1  host access strobe; accepted only when idle.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  host read data, valid the cycle after host_ack.
- host_ack  out  1  one-cycle pulse when the host access is performed.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async) values:
  - val_data = 0, mem_dat = 0, host_rdata = 0, host_ack = 0, busy = 0.
  - state = IDLE, rr_ptr = 0, last_valid = 0.
  - Memory contents are not reset.
- States: IDLE, ACCESS, RESP.
- Eligibility: core k is eligible when mem_req_ld[k] | mem_req_st[k], except core last_id while last_valid = 1. This lockout exists because the core still holds its request during the val_data cycle.
- IDLE:
  - Grant the first eligible core searching rr_ptr, rr_ptr+1, ... mod NUM_CORES.
  - Latch grant id, address, store data, and op. If ld and st are both high on one lane, load wins.
  - Go to ACCESS. last_valid clears on leaving IDLE.
  - If no core is eligible and host_en = 1: perform the host access this cycle (write mem, or read into host_rdata at the edge), pulse host_ack, stay in IDLE.
  - Cores always win over the host.
- ACCESS:
  - Store: mem[addr] <= data.
  - Load: rdata <= mem[addr]. Synchronous read, no read-during-write concern since there is a single port.
  - Go to RESP.
- RESP:
  - At the exit edge: val_data[g] <= 1, and mem_dat lane g <= rdata (load only; store leaves the lane unchanged).
  - rr_ptr <= (g+1) mod NUM_CORES, last_id <= g, last_valid <= 1. Go to IDLE.
- val_data is high exactly one cycle, during the following IDLE cycle, and is then cleared.
- mem_dat lanes hold their value until that lane's next load completes.
- Latency: request visible in IDLE cycle t -> val_data high in cycle t+3. Throughput: one access per 3 cycles.
- Request withdrawn mid-service: the access still completes and val_data still pulses.
- Addresses use the full ADDR_W bits, no wrap logic. Address 0xFFF is valid.
- Reset asserted mid-access: the in-flight store may or may not commit. All handshake outputs return to reset values immediately.

Decomposition:
- Shared package gpu_mem_pkg: ADDR_W/DATA_W defaults, state encoding (IDLE=0, ACCESS=1, RESP=2).
- Sub-module rr_arbiter: request vector + rr_ptr + mask -> grant id and grant valid. Purely combinational priority rotate, reused by the task scheduler.

Test Plan:
- Store then load:
  - Core 3 st addr 0x123 data 0xA5 -> val_data[3] pulses 3 cycles after request.
  - Core 3 ld 0x123 -> mem_dat lane 3 = 0xA5 with val_data[3].
- All 16 cores ld simultaneously with rr_ptr=0 -> val_data order 0,1,...,15, one every 3 cycles.
  - No core is served twice, including the lockout case where core 15 still holds its request.
- Single core holds ld for 2 cycles after val_data (misbehaving) -> served again only after the lockout cycle. Normal core behaviour yields exactly one pulse.
- Host preloads 0x000=0x11 and 0xFFF=0x22 while idle -> host_ack each. Core 0 ld 0xFFF returns 0x22. Host read 0x000 returns 0x11.
- Host_en held while core 5 requests -> core 5 completes first; host_ack only after busy drops with no eligible request.
- Reset pulsed during ACCESS of a load -> val_data stays 0, busy=0 immediately, and the next request is served normally from rr_ptr=0.

Source files
------------

// File: rtl/gpu_mem_pkg.sv
// Shared types and default sizing for the core-to-shared-memory path.
// Pure definitions; no latency or flow control.
package gpu_mem_pkg;

    localparam int NUM_CORES_DEF = 16;
    localparam int ADDR_W_DEF    = 12;
    localparam int DATA_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/shared_mem_ctrl_if.sv
// Core load/store lanes plus host preload port of the shared memory.
// master = cores/host side, slave = memory controller.
interface shared_mem_ctrl_if
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) ();

    logic [NUM_CORES-1:0]        mem_req_ld;
    logic [NUM_CORES-1:0]        mem_req_st;
    logic [NUM_CORES*ADDR_W-1:0] addr_shared_memory;
    logic [NUM_CORES*DATA_W-1:0] mem_dat_st;
    logic [NUM_CORES*DATA_W-1:0] mem_dat;
    logic [NUM_CORES-1:0]        val_data;

    logic                        host_en;
    logic                        host_we;
    logic [ADDR_W-1:0]           host_addr;
    logic [DATA_W-1:0]           host_wdata;
    logic [DATA_W-1:0]           host_rdata;
    logic                        host_ack;
    logic                        busy;

    modport master (
        output mem_req_ld, mem_req_st, addr_shared_memory, mem_dat_st,
        output host_en, host_we, host_addr, host_wdata,
        input  mem_dat, val_data, host_rdata, host_ack, busy
    );

    modport slave (
        input  mem_req_ld, mem_req_st, addr_shared_memory, mem_dat_st,
        input  host_en, host_we, host_addr, host_wdata,
        output mem_dat, val_data, host_rdata, host_ack, busy
    );

endinterface

// File: rtl/shared_mem_ctrl_rr_arbiter.sv
// Round-robin pick of the first unmasked request at or after i_ptr.
// Purely combinational, zero latency; no backpressure.
module rr_arbiter
    import gpu_mem_pkg::*;
#(
    parameter  int N   = NUM_CORES_DEF,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    input  logic [N-1:0]   i_mask,
    output logic [IDW-1:0] o_gnt_id,
    output logic           o_gnt_vld
);

    logic [N-1:0]   w_elig;
    logic [IDW-1:0] w_idx;

    // Scan from the farthest offset down so the nearest eligible lane wins;
    // N is a power of two, so the index wraps without a modulo.
    always_comb begin
        w_elig    = i_req & ~i_mask;
        w_idx     = '0;
        o_gnt_id  = '0;
        o_gnt_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = i_ptr + IDW'(i);
            if (w_elig[w_idx]) begin
                o_gnt_id  = w_idx;
                o_gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_mem_ctrl.sv
// Shared 2**ADDR_W x DATA_W memory serving core lanes round-robin, host when idle.
// Request in IDLE cycle t -> val_data in t+3; cores hold requests until val_data, host waits while busy.
module shared_mem_ctrl
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    shared_mem_ctrl_if.slave mem_if
);

    localparam int IDW   = $clog2(NUM_CORES);
    localparam int DEPTH = 2 ** ADDR_W;

    state_t                      r_state;
    logic [IDW-1:0]              r_rr_ptr;
    logic [IDW-1:0]              r_last_id;
    logic                        r_last_valid;
    logic [IDW-1:0]              r_gnt_id;
    logic                        r_is_ld;
    logic [ADDR_W-1:0]           r_addr;
    logic [DATA_W-1:0]           r_wdata;
    logic [DATA_W-1:0]           r_rdata;
    logic [NUM_CORES-1:0]        r_val_data;
    logic [NUM_CORES*DATA_W-1:0] r_mem_dat;
    logic [DATA_W-1:0]           r_host_rdata;
    logic                        r_host_ack;
    logic                        r_busy;
    logic [DATA_W-1:0]           r_mem [DEPTH];

    logic [NUM_CORES-1:0]        w_req;
    logic [NUM_CORES-1:0]        w_mask;
    logic [IDW-1:0]              w_gnt_id;
    logic                        w_gnt_vld;
    logic [ADDR_W-1:0]           w_gnt_addr;
    logic [DATA_W-1:0]           w_gnt_wdata;
    logic                        w_gnt_ld;
    logic                        w_host_go;
    logic                        w_mem_we;
    logic [ADDR_W-1:0]           w_mem_addr;
    logic [DATA_W-1:0]           w_mem_wdata;
    logic [DATA_W-1:0]           w_mem_rdata;

    // The core just answered still holds its request during the val_data cycle.
    always_comb begin
        w_req  = mem_if.mem_req_ld | mem_if.mem_req_st;
        w_mask = '0;
        if (r_last_valid) begin
            w_mask[r_last_id] = 1'b1;
        end
    end

    rr_arbiter #(.N(NUM_CORES)) u_rr_arbiter (
        .i_req     (w_req),
        .i_ptr     (r_rr_ptr),
        .i_mask    (w_mask),
        .o_gnt_id  (w_gnt_id),
        .o_gnt_vld (w_gnt_vld)
    );

    always_comb begin
        w_gnt_addr  = '0;
        w_gnt_wdata = '0;
        w_gnt_ld    = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (w_gnt_id == IDW'(k)) begin
                w_gnt_addr  = mem_if.addr_shared_memory[k*ADDR_W +: ADDR_W];
                w_gnt_wdata = mem_if.mem_dat_st[k*DATA_W +: DATA_W];
                w_gnt_ld    = mem_if.mem_req_ld[k];
            end
        end
    end

    assign w_host_go = (r_state == IDLE) && !w_gnt_vld && mem_if.host_en;

    // Single memory port shared by the host (IDLE only) and the ACCESS state.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_addr;
        w_mem_wdata = r_wdata;
        if (w_host_go) begin
            w_mem_we    = mem_if.host_we;
            w_mem_addr  = mem_if.host_addr;
            w_mem_wdata = mem_if.host_wdata;
        end else if (r_state == ACCESS) begin
            w_mem_we = !r_is_ld;
        end
    end

    assign w_mem_rdata = r_mem[w_mem_addr];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_last_id    <= '0;
            r_last_valid <= 1'b0;
            r_gnt_id     <= '0;
            r_is_ld      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_val_data   <= '0;
            r_mem_dat    <= '0;
            r_host_rdata <= '0;
            r_host_ack   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_val_data <= '0;
            r_host_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Lockout covers only the val_data cycle, so a core that
                    // keeps requesting is served again on the next pass.
                    r_last_valid <= 1'b0;
                    if (w_gnt_vld) begin
                        r_gnt_id <= w_gnt_id;
                        r_addr   <= w_gnt_addr;
                        r_wdata  <= w_gnt_wdata;
                        r_is_ld  <= w_gnt_ld;
                        r_state  <= ACCESS;
                        r_busy   <= 1'b1;
                    end else if (mem_if.host_en) begin
                        r_host_ack <= 1'b1;
                        if (!mem_if.host_we) begin
                            r_host_rdata <= w_mem_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (r_is_ld) begin
                        r_rdata <= w_mem_rdata;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    r_val_data[r_gnt_id] <= 1'b1;
                    for (int k = 0; k < NUM_CORES; k++) begin
                        if (r_is_ld && (r_gnt_id == IDW'(k))) begin
                            r_mem_dat[k*DATA_W +: DATA_W] <= r_rdata;
                        end
                    end
                    r_rr_ptr     <= r_gnt_id + IDW'(1);
                    r_last_id    <= r_gnt_id;
                    r_last_valid <= 1'b1;
                    r_state      <= IDLE;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_if.mem_dat    = r_mem_dat;
    assign mem_if.val_data   = r_val_data;
    assign mem_if.host_rdata = r_host_rdata;
    assign mem_if.host_ack   = r_host_ack;
    assign mem_if.busy       = r_busy;

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Directed scoreboard bench for shared_mem_ctrl: stimulus pushes expectations,
// a negedge monitor pops and compares against val_data / host_ack / idle state.
module tb_shared_mem_ctrl;

    localparam int NC = 16;
    localparam int AW = 12;
    localparam int DW = 8;
    localparam int CW = NC * DW;

    typedef struct {
        int          core;
        bit          is_ld;
        logic [DW-1:0] data;
        int          cyc;
    } core_exp_t;

    typedef struct {
        bit          is_rd;
        logic [DW-1:0] data;
        int          cyc;
    } host_exp_t;

    typedef struct {
        int          id;
        logic [CW-1:0] mdat;
    } state_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shared_mem_ctrl_if #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) mem_if ();

    shared_mem_ctrl #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk    (clk),
        .reset  (rst),
        .mem_if (mem_if)
    );

    core_exp_t  exp_q [$];
    host_exp_t  host_q [$];
    state_exp_t chk_q [$];

    int total = 0;
    int bad   = 0;
    int tmo   = 0;
    int st_id = 0;
    bit done  = 1'b0;
    bit fin   = 1'b0;
    int drop_cnt [NC];
    int extra [NC];

    // ---------------- monitor / scoreboard ----------------
    core_exp_t     ce;
    host_exp_t     he;
    state_exp_t    se;
    logic [NC-1:0] oh;
    bit            rd_pend = 1'b0;
    logic [DW-1:0] rd_exp;

    task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_q.size() > 0) begin
            se = chk_q.pop_front();
            chk($sformatf("state%0d_busy", se.id), CW'(mem_if.busy), CW'(0));
            chk($sformatf("state%0d_val", se.id), CW'(mem_if.val_data), CW'(0));
            chk($sformatf("state%0d_ack", se.id), CW'(mem_if.host_ack), CW'(0));
            chk($sformatf("state%0d_mem_dat", se.id), mem_if.mem_dat, se.mdat);
        end
        if (mem_if.val_data != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_val_data", CW'(mem_if.val_data), CW'(0));
            end else begin
                ce = exp_q.pop_front();
                oh = '0;
                oh[ce.core] = 1'b1;
                chk($sformatf("val_core%0d", ce.core), CW'(mem_if.val_data), CW'(oh));
                chk($sformatf("lat_core%0d", ce.core), CW'(cyc), CW'(ce.cyc));
                if (ce.is_ld) begin
                    chk($sformatf("ldat_core%0d", ce.core),
                        CW'(mem_if.mem_dat[ce.core*DW +: DW]), CW'(ce.data));
                end
            end
        end
        if (rd_pend) begin
            chk("host_rdata", CW'(mem_if.host_rdata), CW'(rd_exp));
            rd_pend = 1'b0;
        end
        if (mem_if.host_ack) begin
            if (host_q.size() == 0) begin
                chk("unexpected_host_ack", CW'(mem_if.host_ack), CW'(0));
            end else begin
                he = host_q.pop_front();
                chk("host_ack_cycle", CW'(cyc), CW'(he.cyc));
                if (he.is_rd) begin
                    rd_pend = 1'b1;
                    rd_exp  = he.data;
                end
            end
        end
        if (done && !fin) begin
            fin = 1'b1;
            chk("core_exp_left", CW'(exp_q.size()), CW'(0));
            chk("host_exp_left", CW'(host_q.size()), CW'(0));
            chk("wait_timeouts", CW'(tmo), CW'(0));
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    // A well-behaved core samples val_data at the edge ending its pulse and
    // lowers its request after that edge; extra[k] stretches the hold.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < NC; k++) begin
            if (drop_cnt[k] > 0) begin
                drop_cnt[k]--;
                if (drop_cnt[k] == 0) begin
                    mem_if.mem_req_ld[k] = 1'b0;
                    mem_if.mem_req_st[k] = 1'b0;
                end
            end
            if (mem_if.val_data[k]) drop_cnt[k] = 1 + extra[k];
        end
    endtask

    task automatic exp_push(input int k, input bit is_ld, input logic [DW-1:0] d, input int c);
        core_exp_t e;
        e.core = k; e.is_ld = is_ld; e.data = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic core_req(input int k, input bit is_ld, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int c);
        mem_if.addr_shared_memory[k*AW +: AW] = a;
        mem_if.mem_dat_st[k*DW +: DW] = d;
        if (is_ld) mem_if.mem_req_ld[k] = 1'b1;
        else       mem_if.mem_req_st[k] = 1'b1;
        exp_push(k, is_ld, d, c);
    endtask

    task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
        host_exp_t h;
        int n;
        h.is_rd = !we; h.data = d; h.cyc = c;
        host_q.push_back(h);
        mem_if.host_en    = 1'b1;
        mem_if.host_we    = we;
        mem_if.host_addr  = a;
        mem_if.host_wdata = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_if.host_ack && n < 60);
        if (!mem_if.host_ack) tmo++;
        mem_if.host_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || host_q.size() != 0 || mem_if.busy) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) tmo++;
        repeat (4) tick();
    endtask

    task automatic push_state(input logic [CW-1:0] md);
        state_exp_t s;
        s.id = st_id; s.mdat = md;
        st_id++;
        chk_q.push_back(s);
    endtask

    logic [CW-1:0] md;
    int            c0;

    initial begin
        for (int k = 0; k < NC; k++) begin
            drop_cnt[k] = 0;
            extra[k]    = 0;
        end
        rst = 1'b1;
        mem_if.mem_req_ld         = '0;
        mem_if.mem_req_st         = '0;
        mem_if.addr_shared_memory = '0;
        mem_if.mem_dat_st         = '0;
        mem_if.host_en            = 1'b0;
        mem_if.host_we            = 1'b0;
        mem_if.host_addr          = '0;
        mem_if.host_wdata         = '0;

        repeat (3) tick();
        push_state('0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // store then load on core 3; a later store must not touch lane 3
        core_req(3, 1'b0, 12'h123, 8'hA5, cyc + 3);
        wait_idle();
        core_req(3, 1'b1, 12'h123, 8'hA5, cyc + 3);
        wait_idle();
        core_req(3, 1'b0, 12'h124, 8'h77, cyc + 3);
        wait_idle();
        md = '0;
        md[3*DW +: DW] = 8'hA5;
        push_state(md);
        tick();

        // host preload of both address extremes, core readback, host readback
        host_op(1'b1, 12'h000, 8'h11, cyc + 1);
        host_op(1'b1, 12'hFFF, 8'h22, cyc + 1);
        tick();
        core_req(0, 1'b1, 12'hFFF, 8'h22, cyc + 3);
        wait_idle();
        host_op(1'b0, 12'h000, 8'h11, cyc + 1);
        wait_idle();

        // host waits behind core 5, then slips into the lockout cycle
        core_req(5, 1'b1, 12'h123, 8'hA5, cyc + 3);
        host_op(1'b0, 12'hFFF, 8'h22, cyc + 4);
        wait_idle();
        md = '0;
        md[0*DW +: DW] = 8'h22;
        md[3*DW +: DW] = 8'hA5;
        md[5*DW +: DW] = 8'hA5;
        push_state(md);
        tick();

        // reset during ACCESS of a core 9 load: no pulse, outputs cleared
        mem_if.addr_shared_memory[9*AW +: AW] = 12'h123;
        mem_if.mem_req_ld[9] = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        mem_if.mem_req_ld[9] = 1'b0;
        push_state('0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        // rr_ptr restarts at 0: core 2 before core 14; memory survives reset
        c0 = cyc;
        core_req(2, 1'b1, 12'h123, 8'hA5, c0 + 3);
        core_req(14, 1'b1, 12'hFFF, 8'h22, c0 + 6);
        wait_idle();

        // preload 0x400..0x40E by host, 0x40F by core 15 (leaves rr_ptr at 0)
        for (int k = 0; k < NC - 1; k++) begin
            host_op(1'b1, AW'(12'h400 + k), DW'(8'h60 + k), cyc + 1);
        end
        tick();
        core_req(15, 1'b0, 12'h40F, 8'h6F, cyc + 3);
        wait_idle();

        // all cores load at once: served 0..15, one every 3 cycles
        c0 = cyc;
        for (int k = 0; k < NC; k++) begin
            core_req(k, 1'b1, AW'(12'h400 + k), DW'(8'h60 + k), c0 + 3 * (k + 1));
        end
        wait_idle();
        md = '0;
        for (int k = 0; k < NC; k++) md[k*DW +: DW] = DW'(8'h60 + k);
        push_state(md);
        tick();

        // core 7 holds its load 2 cycles past val_data: served twice, second
        // pass completes even though the request drops mid-service
        extra[7] = 2;
        c0 = cyc;
        core_req(7, 1'b1, 12'h407, 8'h67, c0 + 3);
        exp_push(7, 1'b1, 8'h67, c0 + 7);
        wait_idle();
        extra[7] = 0;

        done = 1'b1;
        repeat (5) tick();
        tmo++;
        done = 1'b1;
        forever tick();
    end

endmodule
